status_register_unit: RTL and testbench

- Producer side of the NZCV status interface. Computes condition flags from the EXE-stage ALU outcome for S-bit instructions and holds the architectural status register (SR).
- Also holds a one-deep saved copy (SPSR) for exception entry and return, and accepts direct MSR flag writes.
- SR drives the ID-stage condition checker; sr_next is a same-cycle forwarded value used for hazard-free flag reads.

---
 rtl/arm_defs_pkg.sv | 25 ++
 rtl/status_register_unit_if.sv | 33 +++
 rtl/flag_gen.sv | 45 ++++
 rtl/status_register_unit.sv | 98 +++++++++
 tb/tb_status_register_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/arm_defs_pkg.sv
// rtl/arm_defs_pkg.sv - shared EXE command encodings, flag indices and SR FSM state type
package arm_defs_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_NORM = 1'b0,
    ST_EXC  = 1'b1
  } sr_state_t;

endpackage

// File: rtl/status_register_unit_if.sv
// rtl/status_register_unit_if.sv - EXE-side flag inputs and status outputs of the status register unit
interface status_register_unit_if #(
  parameter int WIDTH = 32
);
  logic             freeze;
  logic             flush;
  logic             s_bit;
  logic [3:0]       exe_cmd;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;
  logic             msr_we;
  logic [3:0]       msr_data;
  logic             exc_entry;
  logic             exc_return;
  logic [3:0]       sr;
  logic [3:0]       sr_next;
  logic [3:0]       spsr;
  logic             in_exception;
  logic             ret_error;

  modport master (
    output freeze, flush, s_bit, exe_cmd, alu_result, alu_c, alu_v,
           msr_we, msr_data, exc_entry, exc_return,
    input  sr, sr_next, spsr, in_exception, ret_error
  );

  modport slave (
    input  freeze, flush, s_bit, exe_cmd, alu_result, alu_c, alu_v,
           msr_we, msr_data, exc_entry, exc_return,
    output sr, sr_next, spsr, in_exception, ret_error
  );
endinterface

// File: rtl/flag_gen.sv
// rtl/flag_gen.sv - combinational NZCV computation from the EXE ALU outcome
module flag_gen
  import arm_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             c_cur,
  input  logic             v_cur,
  output logic [3:0]       flags,
  output logic             flags_valid
);

  logic c_out;
  logic v_out;

  // Arithmetic ops take C/V from the ALU, logical ops keep them; NOP and unused codes never update.
  always_comb begin
    flags_valid = 1'b0;
    c_out       = c_cur;
    v_out       = v_cur;
    unique case (exe_cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        flags_valid = 1'b1;
        c_out       = alu_c;
        v_out       = alu_v;
      end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
        flags_valid = 1'b1;
      end
      default: begin
        flags_valid = 1'b0;
      end
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = alu_result[WIDTH-1];
    flags[FLAG_Z] = (alu_result == '0);
    flags[FLAG_C] = c_out;
    flags[FLAG_V] = v_out;
  end

endmodule

// File: rtl/status_register_unit.sv
// rtl/status_register_unit.sv - architectural NZCV status register with saved copy and exception FSM
module status_register_unit
  import arm_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  status_register_unit_if.slave bus
);

  logic [3:0] sr_q;
  logic [3:0] spsr_q;
  logic [3:0] sr_nxt;
  logic       ret_err_q;
  logic [3:0] alu_flags;
  logic       alu_flags_valid;
  logic       alu_upd;
  logic       ret_legal;
  logic       ret_illegal;
  sr_state_t  state_q;
  sr_state_t  state_d;

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .exe_cmd     (bus.exe_cmd),
    .alu_result  (bus.alu_result),
    .alu_c       (bus.alu_c),
    .alu_v       (bus.alu_v),
    .c_cur       (sr_q[FLAG_C]),
    .v_cur       (sr_q[FLAG_V]),
    .flags       (alu_flags),
    .flags_valid (alu_flags_valid)
  );

  assign alu_upd     = bus.s_bit & ~bus.flush & ~bus.freeze;
  assign ret_legal   = bus.exc_return & (state_q == ST_EXC);
  assign ret_illegal = bus.exc_return & (state_q == ST_NORM);

  // Forwarded SR value: stall, legal return, MSR write, ALU update, hold -- in that priority.
  always_comb begin
    sr_nxt = sr_q;
    if (bus.freeze) begin
      sr_nxt = sr_q;
    end else if (ret_legal) begin
      sr_nxt = spsr_q;
    end else if (bus.msr_we) begin
      sr_nxt = bus.msr_data;
    end else if (alu_upd && alu_flags_valid) begin
      sr_nxt = alu_flags;
    end
  end

  // SR, SPSR and the illegal-return pulse; the entry snapshot sees the already-resolved sr_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= 4'b0000;
      spsr_q    <= 4'b0000;
      ret_err_q <= 1'b0;
    end else begin
      sr_q      <= sr_nxt;
      ret_err_q <= ~bus.freeze & ret_illegal;
      if (!bus.freeze && bus.exc_entry) begin
        spsr_q <= sr_nxt;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: return is resolved before entry, so entry wins when both arrive together.
  always_comb begin
    state_d = state_q;
    if (!bus.freeze) begin
      unique case (state_q)
        ST_NORM: if (bus.exc_entry) state_d = ST_EXC;
        ST_EXC:  if (bus.exc_return && !bus.exc_entry) state_d = ST_NORM;
        default: state_d = ST_NORM;
      endcase
    end
  end

  // FSM outputs and register views.
  always_comb begin
    bus.in_exception = (state_q == ST_EXC);
    bus.sr           = sr_q;
    bus.sr_next      = sr_nxt;
    bus.spsr         = spsr_q;
    bus.ret_error    = ret_err_q;
  end

endmodule

// File: tb/tb_status_register_unit.sv
// tb/tb_status_register_unit.sv - table-driven scoreboard bench for the status register unit
module tb_status_register_unit;
  import arm_defs_pkg::*;

  typedef struct {
    logic        freeze;
    logic        flush;
    logic        s_bit;
    logic [3:0]  cmd;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        msr_we;
    logic [3:0]  msr_data;
    logic        entry;
    logic        ret;
    logic [3:0]  e_next;
    logic [3:0]  e_sr;
    logic [3:0]  e_spsr;
    logic        e_exc;
    logic        e_rerr;
  } vec_t;

  typedef struct {
    logic [3:0] sr;
    logic [3:0] spsr;
    logic       exc;
    logic       rerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  status_register_unit_if #(.WIDTH(32)) bus ();

  status_register_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic fz, logic fl, logic s, logic [3:0] cmd, logic [31:0] res,
                              logic c, logic v, logic mw, logic [3:0] md, logic en, logic rt,
                              logic [3:0] enext, logic [3:0] esr, logic [3:0] espsr,
                              logic eexc, logic erer);
    vec_t t;
    t.freeze = fz; t.flush = fl; t.s_bit = s; t.cmd = cmd; t.res = res; t.c = c; t.v = v;
    t.msr_we = mw; t.msr_data = md; t.entry = en; t.ret = rt;
    t.e_next = enext; t.e_sr = esr; t.e_spsr = espsr; t.e_exc = eexc; t.e_rerr = erer;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic drive(vec_t t);
    bus.freeze     = t.freeze;
    bus.flush      = t.flush;
    bus.s_bit      = t.s_bit;
    bus.exe_cmd    = t.cmd;
    bus.alu_result = t.res;
    bus.alu_c      = t.c;
    bus.alu_v      = t.v;
    bus.msr_we     = t.msr_we;
    bus.msr_data   = t.msr_data;
    bus.exc_entry  = t.entry;
    bus.exc_return = t.ret;
  endtask

  task automatic check_regs(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".sr"}, 32'(bus.sr), 32'(e.sr));
    check({tag, ".spsr"}, 32'(bus.spsr), 32'(e.spsr));
    check({tag, ".in_exception"}, 32'(bus.in_exception), 32'(e.exc));
    check({tag, ".ret_error"}, 32'(bus.ret_error), 32'(e.rerr));
  endtask

  // Drive at negedge, check forwarded value mid-cycle, then check registered values after the edge.
  task automatic apply(vec_t t, string tag);
    exp_t e;
    @(negedge clk);
    drive(t);
    #1;
    check({tag, ".sr_next"}, 32'(bus.sr_next), 32'(t.e_next));
    e.sr = t.e_sr; e.spsr = t.e_spsr; e.exc = t.e_exc; e.rerr = t.e_rerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    vec_t idle;
    exp_t e;
    idle = mk(0,0,0,CMD_NOP,32'h0,0,0,0,4'h0,0,0, 4'h0,4'h0,4'h0,0,0);
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e.sr = 4'b0000; e.spsr = 4'b0000; e.exc = 1'b0; e.rerr = 1'b0;
    sb.push_back(e);
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    //            fz fl s  cmd      res           c v mw md       en rt  next     sr       spsr    exc rerr
    vecs.push_back(mk(0,0,1,CMD_ADD,32'h0000_0000,1,0,0,4'b0000,0,0, 4'b0110,4'b0110,4'b0000,0,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b0011,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,0,1,CMD_AND,32'h8000_0000,0,0,0,4'b0000,0,0, 4'b1011,4'b1011,4'b0000,0,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b0011,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,1,1,CMD_AND,32'h8000_0000,0,0,0,4'b0000,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,0,1,4'b1111,32'h0000_0000,1,1,0,4'b0000,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,0,1,CMD_NOP,32'h0000_0000,1,1,0,4'b0000,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,0,0,CMD_SUB,32'h0000_0000,1,0,0,4'b0000,0,0, 4'b0011,4'b0011,4'b0000,0,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b1000,0,0, 4'b1000,4'b1000,4'b0000,0,0));
    vecs.push_back(mk(0,0,1,CMD_SUB,32'h0000_0005,1,0,0,4'b0000,1,0, 4'b0010,4'b0010,4'b0010,1,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b1111,0,0, 4'b1111,4'b1111,4'b0010,1,0));
    vecs.push_back(mk(0,0,1,CMD_ADD,32'h0000_0000,1,1,1,4'b0101,0,1, 4'b0010,4'b0010,4'b0010,0,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b0101,0,1, 4'b0101,4'b0101,4'b0010,0,1));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,0,4'b0000,0,0, 4'b0101,4'b0101,4'b0010,0,0));
    vecs.push_back(mk(0,0,1,CMD_ADD,32'h0000_0001,0,0,1,4'b1001,0,0, 4'b1001,4'b1001,4'b0010,0,0));
    vecs.push_back(mk(0,0,1,CMD_EOR,32'h0000_0000,0,0,0,4'b0000,0,0, 4'b0101,4'b0101,4'b0010,0,0));
    vecs.push_back(mk(0,0,1,CMD_SBC,32'hFFFF_FFFF,0,1,0,4'b0000,0,0, 4'b1001,4'b1001,4'b0010,0,0));
    vecs.push_back(mk(0,0,1,CMD_MVN,32'h7FFF_FFFF,1,0,0,4'b0000,0,0, 4'b0001,4'b0001,4'b0010,0,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,0,4'b0000,1,0, 4'b0001,4'b0001,4'b0001,1,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b0110,0,0, 4'b0110,4'b0110,4'b0001,1,0));
    vecs.push_back(mk(0,0,1,CMD_ADC,32'h0000_0000,0,1,0,4'b0000,1,0, 4'b0101,4'b0101,4'b0101,1,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b1100,0,0, 4'b1100,4'b1100,4'b0101,1,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,1,4'b0011,1,1, 4'b0101,4'b0101,4'b0101,1,0));
    vecs.push_back(mk(0,0,0,CMD_NOP,32'h0000_0000,0,0,0,4'b0000,0,1, 4'b0101,4'b0101,4'b0101,0,0));
    vecs.push_back(mk(0,0,1,CMD_ORR,32'h0000_0010,0,0,0,4'b0000,0,0, 4'b0001,4'b0001,4'b0101,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Freeze held for three cycles blocks ALU, MSR and entry; release lets the same inputs land.
    for (int k = 0; k < 3; k++) begin
      apply(mk(1,0,1,CMD_ADD,32'h0,1,0,1,4'b1111,1,0, 4'b0001,4'b0001,4'b0101,0,0),
            $sformatf("freeze%0d", k));
    end
    apply(mk(0,0,1,CMD_ADD,32'h0,1,0,1,4'b1111,1,0, 4'b1111,4'b1111,4'b1111,1,0), "unfreeze");

    // Frozen return in EXC is ignored; the later unfrozen return restores SPSR.
    apply(mk(1,0,0,CMD_NOP,32'h0,0,0,1,4'b0000,0,1, 4'b1111,4'b1111,4'b1111,1,0), "frz_ret");
    apply(mk(0,0,0,CMD_NOP,32'h0,0,0,1,4'b0000,0,1, 4'b1111,4'b1111,4'b1111,0,0), "ret_ok");

    // Illegal return with an ALU update: flags still commit, pulse lasts exactly one cycle.
    apply(mk(0,0,1,CMD_SUB,32'h0,1,1,0,4'b0000,0,1, 4'b0111,4'b0111,4'b1111,0,1), "bad_ret");
    apply(idle_with(4'b0111, 4'b1111), "bad_ret_p1");
    apply(idle_with(4'b0111, 4'b1111), "bad_ret_p2");

    // Synchronous reset mid-exception wins over a concurrent MSR write.
    apply(mk(0,0,0,CMD_NOP,32'h0,0,0,0,4'b0000,1,0, 4'b0111,4'b0111,4'b0111,1,0), "pre_rst");
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0,0,0,CMD_NOP,32'h0,0,0,1,4'b1010,0,0, 4'h0,4'h0,4'h0,0,0));
    e.sr = 4'b0000; e.spsr = 4'b0000; e.exc = 1'b0; e.rerr = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_regs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(idle);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic vec_t idle_with(logic [3:0] s, logic [3:0] sp);
    return mk(0,0,0,CMD_NOP,32'h0,0,0,0,4'b0000,0,0, s,s,sp,0,0);
  endfunction

endmodule
